// File: rtl/axi_checker_pkg.sv
// Shared types and constants for the AXI full read/write protocol checker.
package axi_checker_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // A burst is good only when WLAST lands on the beat index announced by AWLEN.
  function automatic logic [1:0] wlast_resp(input logic [8:0] beat, input logic [7:0] len);
    return (beat == {1'b0, len}) ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi_checker_sat_cnt.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module axi_checker_sat_cnt #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/axi_checker_full_rw.sv
// AXI4 slave that checks write-burst WLAST placement and serves reads with
// address-plus-beat data; independent single-outstanding write and read paths.
module axi_checker_full_rw
  import axi_checker_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 6,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESET,
  // AW
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                  S_AXI_AWLEN,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  // W
  input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                        S_AXI_WLAST,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  // B
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  // AR
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                  S_AXI_ARLEN,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  // R
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RLAST,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  // Statistics
  output logic [CNT_WIDTH-1:0]        WR_BURST_CNT,
  output logic [CNT_WIDTH-1:0]        RD_BURST_CNT,
  output logic [CNT_WIDTH-1:0]        WLAST_ERR_CNT
);

  // Handshake rule on every channel: a transfer happens on the rising edge
  // where VALID and READY are both 1; a source never drops VALID or changes
  // its payload until that edge, and READY/VALID from this block are registers.

  wr_state_t                   wr_state;
  logic [AXI_ID_WIDTH-1:0]     aw_id_q;
  logic [7:0]                  aw_len_q;
  logic [8:0]                  wr_beat;

  rd_state_t                   rd_state;
  logic [AXI_ID_WIDTH-1:0]     ar_id_q;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_q;
  logic [7:0]                  ar_len_q;
  logic [8:0]                  rd_beat;
  logic [8:0]                  rd_beat_nxt;

  logic                        wr_done;
  logic                        err_done;
  logic                        rd_done;
  logic                        unused_wpayload;

  // Write payload is deliberately not inspected.
  assign unused_wpayload = ^{S_AXI_WDATA, S_AXI_WSTRB};

  assign S_AXI_BID   = aw_id_q;
  assign S_AXI_RID   = ar_id_q;
  assign S_AXI_RRESP = RESP_OKAY;
  assign rd_beat_nxt = rd_beat + 9'd1;

  // ---------------- write path ----------------
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wr_state      <= W_IDLE;
      aw_id_q       <= '0;
      aw_len_q      <= '0;
      wr_beat       <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          S_AXI_AWREADY <= 1'b1;
          if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            aw_id_q       <= S_AXI_AWID;
            aw_len_q      <= S_AXI_AWLEN;
            wr_beat       <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            wr_state      <= W_DATA;
          end
        end
        W_DATA: begin
          // Without WLAST the burst simply keeps absorbing beats.
          if (S_AXI_WVALID && S_AXI_WREADY) begin
            wr_beat <= wr_beat + 9'd1;
            if (S_AXI_WLAST) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              S_AXI_BRESP  <= wlast_resp(wr_beat, aw_len_q);
              wr_state     <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            wr_state      <= W_IDLE;
          end
        end
        default: begin
          S_AXI_AWREADY <= 1'b0;
          S_AXI_WREADY  <= 1'b0;
          S_AXI_BVALID  <= 1'b0;
          wr_state      <= W_IDLE;
        end
      endcase
    end
  end

  // ---------------- read path ----------------
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rd_state      <= R_IDLE;
      ar_id_q       <= '0;
      ar_addr_q     <= '0;
      ar_len_q      <= '0;
      rd_beat       <= '0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RLAST   <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          S_AXI_ARREADY <= 1'b1;
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            ar_id_q       <= S_AXI_ARID;
            ar_addr_q     <= S_AXI_ARADDR;
            ar_len_q      <= S_AXI_ARLEN;
            rd_beat       <= '0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RDATA   <= AXI_DATA_WIDTH'(S_AXI_ARADDR);
            S_AXI_RLAST   <= (S_AXI_ARLEN == 8'd0);
            rd_state      <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RVALID && S_AXI_RREADY) begin
            if (S_AXI_RLAST) begin
              S_AXI_RVALID  <= 1'b0;
              S_AXI_RLAST   <= 1'b0;
              S_AXI_ARREADY <= 1'b1;
              rd_state      <= R_IDLE;
            end else begin
              // Nine-bit beat index so ARLEN=255 never wraps.
              rd_beat     <= rd_beat_nxt;
              S_AXI_RDATA <= AXI_DATA_WIDTH'(ar_addr_q) + AXI_DATA_WIDTH'(rd_beat_nxt);
              S_AXI_RLAST <= (rd_beat_nxt == {1'b0, ar_len_q});
            end
          end
        end
        default: begin
          S_AXI_ARREADY <= 1'b0;
          S_AXI_RVALID  <= 1'b0;
          S_AXI_RLAST   <= 1'b0;
          rd_state      <= R_IDLE;
        end
      endcase
    end
  end

  // ---------------- statistics ----------------
  assign wr_done  = S_AXI_BVALID && S_AXI_BREADY;
  assign err_done = wr_done && (S_AXI_BRESP == RESP_SLVERR);
  assign rd_done  = S_AXI_RVALID && S_AXI_RREADY && S_AXI_RLAST;

  axi_checker_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
    .clk   (S_AXI_ACLK),
    .reset (S_AXI_ARESET),
    .inc   (wr_done),
    .count (WR_BURST_CNT)
  );

  axi_checker_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_rd_cnt (
    .clk   (S_AXI_ACLK),
    .reset (S_AXI_ARESET),
    .inc   (rd_done),
    .count (RD_BURST_CNT)
  );

  axi_checker_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (S_AXI_ACLK),
    .reset (S_AXI_ARESET),
    .inc   (err_done),
    .count (WLAST_ERR_CNT)
  );

endmodule

// File: tb/tb_axi_checker_full_rw.sv
// Bench for axi_checker_full_rw: table-driven bursts, hand-written corner
// sequences and random concurrent traffic against a transaction-level model.
module tb_axi_checker_full_rw;
  import axi_checker_pkg::*;

  localparam int IDW = 1;
  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int CW  = 16;
  localparam int CW2 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  logic [IDW-1:0]  awid, arid;
  logic [AW-1:0]   awaddr, araddr;
  logic [7:0]      awlen, arlen;
  logic            awvalid, wvalid, wlast, bready, arvalid, rready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;

  logic            awready, wready, bvalid, arready, rvalid, rlast;
  logic [IDW-1:0]  bid, rid;
  logic [1:0]      bresp, rresp;
  logic [DW-1:0]   rdata;
  logic [CW-1:0]   wr_cnt, rd_cnt, err_cnt;

  logic            awready_s, wready_s, bvalid_s, arready_s, rvalid_s, rlast_s;
  logic [IDW-1:0]  bid_s, rid_s;
  logic [1:0]      bresp_s, rresp_s;
  logic [DW-1:0]   rdata_s;
  logic [CW2-1:0]  wr_cnt_s, rd_cnt_s, err_cnt_s;

  axi_checker_full_rw #(
    .AXI_ID_WIDTH(IDW), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(areset),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .WR_BURST_CNT(wr_cnt), .RD_BURST_CNT(rd_cnt), .WLAST_ERR_CNT(err_cnt)
  );

  // Narrow-counter copy fed with identical traffic, used for saturation checks.
  axi_checker_full_rw #(
    .AXI_ID_WIDTH(IDW), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .CNT_WIDTH(CW2)
  ) dut_sat (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(areset),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready_s),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_s),
    .S_AXI_BID(bid_s), .S_AXI_BRESP(bresp_s), .S_AXI_BVALID(bvalid_s), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_s),
    .S_AXI_RID(rid_s), .S_AXI_RDATA(rdata_s), .S_AXI_RRESP(rresp_s), .S_AXI_RLAST(rlast_s),
    .S_AXI_RVALID(rvalid_s), .S_AXI_RREADY(rready),
    .WR_BURST_CNT(wr_cnt_s), .RD_BURST_CNT(rd_cnt_s), .WLAST_ERR_CNT(err_cnt_s)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int n_wr   = 0;
  int n_rd   = 0;
  int n_err  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT did not respond within the cycle budget", name);
  endtask

  // Reference rules: a burst is OKAY only if WLAST sits on beat index AWLEN.
  function automatic logic [1:0] model_bresp(input int len, input int wlast_beat);
    return (wlast_beat == len) ? 2'b00 : 2'b10;
  endfunction

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_wr_cnt"},  wr_cnt,    sat(n_wr, CW));
    check({tag, "_rd_cnt"},  rd_cnt,    sat(n_rd, CW));
    check({tag, "_err_cnt"}, err_cnt,   sat(n_err, CW));
    check({tag, "_wr_sat"},  wr_cnt_s,  sat(n_wr, CW2));
    check({tag, "_rd_sat"},  rd_cnt_s,  sat(n_rd, CW2));
    check({tag, "_err_sat"}, err_cnt_s, sat(n_err, CW2));
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end on a falling edge.
  task automatic do_write(input logic [IDW-1:0] id, input int len, input int wlast_beat,
                          input logic [1:0] exp_resp);
    int t;
    awid = id; awaddr = AW'($urandom_range(0, 63)); awlen = 8'(len); awvalid = 1'b1;
    t = 0;
    while (!awready && t < 200) begin @(negedge clk); t++; end
    if (!awready) begin timeout("aw_handshake"); awvalid = 1'b0; return; end
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b <= wlast_beat; b++) begin
      if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge clk); end
      wvalid = 1'b1; wlast = (b == wlast_beat); wdata = $urandom; wstrb = 4'($urandom_range(0, 15));
      t = 0;
      while (!wready && t < 200) begin @(negedge clk); t++; end
      if (!wready) begin timeout("w_handshake"); wvalid = 1'b0; wlast = 1'b0; return; end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("b_latency", bvalid, 1'b1);
    t = 0;
    while (!bvalid && t < 200) begin @(negedge clk); t++; end
    if (!bvalid) begin timeout("b_wait"); return; end
    check("bresp", bresp, exp_resp);
    check("bid", bid, id);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("bvalid_hold", bvalid, 1'b1);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    n_wr++;
    if (exp_resp == 2'b10) n_err++;
    check("awready_after_b", awready, 1'b1);
    check("bvalid_drop", bvalid, 1'b0);
  endtask

  // mode 0: RREADY held high, 1: toggling, 2: random
  task automatic do_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len,
                         input int mode);
    logic [DW-1:0] exp_q[$];
    int t;
    int cyc;
    logic r;
    arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
    t = 0;
    while (!arready && t < 200) begin @(negedge clk); t++; end
    if (!arready) begin timeout("ar_handshake"); arvalid = 1'b0; return; end
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i <= len; i++) exp_q.push_back(DW'(addr) + DW'(i));
    check("r_latency", rvalid, 1'b1);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      if (rvalid !== 1'b1) begin
        check("rvalid", rvalid, 1'b1);
        break;
      end
      check("rdata", rdata, exp_q[0]);
      check("rlast", rlast, exp_q.size() == 1);
      check("rid", rid, id);
      check("rresp", rresp, 2'b00);
      if (mode == 0)      r = 1'b1;
      else if (mode == 1) r = cyc[0];
      else                r = 1'($urandom_range(0, 1));
      rready = r;
      if (r) begin
        if (exp_q.size() == 1) n_rd++;
        void'(exp_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    if (exp_q.size() > 0) begin timeout("r_burst"); return; end
    check("arready_after_r", arready, 1'b1);
    check("rvalid_drop", rvalid, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [IDW-1:0] awid;
    int             awlen;
    int             wlast_beat;
    logic [1:0]     exp_bresp;
    logic [IDW-1:0] arid;
    logic [AW-1:0]  araddr;
    int             arlen;
    int             rmode;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 3, 3, 2'b00, 1'b0, 6'h10, 2,   1};
    vecs[1] = '{1'b0, 3, 1, 2'b10, 1'b1, 6'h3f, 0,   0};
    vecs[2] = '{1'b1, 0, 0, 2'b00, 1'b1, 6'h20, 255, 2};
    vecs[3] = '{1'b0, 1, 3, 2'b10, 1'b0, 6'h3e, 3,   2};
    vecs[4] = '{1'b1, 7, 7, 2'b00, 1'b0, 6'h00, 1,   0};

    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    areset = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_awready", awready, 1'b0);
    check("rst_wready",  wready,  1'b0);
    check("rst_bvalid",  bvalid,  1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_rvalid",  rvalid,  1'b0);
    check("rst_rlast",   rlast,   1'b0);
    check("rst_bresp",   bresp,   2'b00);
    check("rst_bid",     bid,     '0);
    check("rst_rid",     rid,     '0);
    check("rst_rdata",   rdata,   '0);
    check_counters("rst");

    areset = 1'b0;
    @(negedge clk);
    check("post_rst_awready", awready, 1'b1);
    check("post_rst_arready", arready, 1'b1);

    // Table: each row runs a write burst and a read burst concurrently.
    for (int v = 0; v < 5; v++) begin
      fork
        do_write(vecs[v].awid, vecs[v].awlen, vecs[v].wlast_beat, vecs[v].exp_bresp);
        do_read(vecs[v].arid, vecs[v].araddr, vecs[v].arlen, vecs[v].rmode);
      join
      check_counters($sformatf("vec%0d", v));
    end

    // Reset arriving while W beat 2 is on the bus abandons the burst.
    awid = 1'b1; awlen = 8'd3; awvalid = 1'b1;
    while (!awready) @(negedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wvalid = 1'b1; wlast = 1'b0;
      @(negedge clk);
      check("mid_rst_wready", wready, 1'b1);
    end
    wvalid = 1'b1;
    areset = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("mid_rst_bvalid", bvalid, 1'b0);
    check("mid_rst_awready", awready, 1'b0);
    @(negedge clk);
    areset = 1'b0;
    n_wr = 0; n_rd = 0; n_err = 0;
    @(negedge clk);
    check("rel_awready", awready, 1'b1);
    check("rel_wready", wready, 1'b0);
    repeat (3) begin
      check("rel_no_bvalid", bvalid, 1'b0);
      @(negedge clk);
    end
    check_counters("post_mid_rst");

    // Five good bursts drive the 2-bit counter into saturation.
    for (int i = 0; i < 5; i++) begin
      do_write(1'($urandom_range(0, 1)), 1, 1, 2'b00);
      check("sat_wr_step", wr_cnt_s, sat(i + 1, CW2));
    end
    check("sat_wr_hold", wr_cnt_s, 2'd3);
    check("sat_wr_full", wr_cnt, 16'd5);

    // Random concurrent traffic.
    for (int k = 0; k < 16; k++) begin
      int len, wl, rlen;
      logic [IDW-1:0] wid, rdid;
      logic [AW-1:0] addr;
      len  = $urandom_range(0, 7);
      wl   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : len;
      rlen = $urandom_range(0, 15);
      wid  = 1'($urandom_range(0, 1));
      rdid = 1'($urandom_range(0, 1));
      addr = AW'($urandom_range(0, 63));
      fork
        do_write(wid, len, wl, model_bresp(len, wl));
        do_read(rdid, addr, rlen, 2);
      join
    end
    check_counters("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
